// File: rtl/mem_request_sequencer.sv
// Memory request front end: accepts one read or write at a time, drives the memory strobes
// and the completion counter for the access window, and reports done/error with a watchdog.
module mem_request_sequencer #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RD_LAT  = 4,
  parameter int WR_LAT  = 2,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_busy,
  output logic              req_done,
  output logic              req_error,
  output logic [DATA_W-1:0] req_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ren,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cc_enable,
  output logic [3:0]        cc_max,
  input  logic              cc_cmp
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int WD_W = $clog2(TIMEOUT) + 1;
  localparam logic [3:0]      RD_MAX  = 4'(RD_LAT);
  localparam logic [3:0]      WR_MAX  = 4'(WR_LAT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_SAT  = '1;

  state_t          state_reg;
  logic            op_read_reg;
  logic [WD_W-1:0] wd_reg;

  // req_error doubles as the internal error flag; it is only meaningful alongside req_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      op_read_reg <= 1'b0;
      wd_reg      <= '0;
      req_busy    <= 1'b0;
      req_done    <= 1'b0;
      req_error   <= 1'b0;
      req_rdata   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_ren     <= 1'b0;
      mem_wen     <= 1'b0;
      cc_enable   <= 1'b0;
      cc_max      <= '0;
    end else begin
      req_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          req_error <= 1'b0;
          if (req_read ^ req_write) begin
            mem_addr    <= req_addr;
            mem_wdata   <= req_wdata;
            op_read_reg <= req_read;
            cc_max      <= req_read ? RD_MAX : WR_MAX;
            mem_ren     <= req_read;
            mem_wen     <= req_write;
            cc_enable   <= 1'b1;
            req_busy    <= 1'b1;
            state_reg   <= ACCESS;
          end else if (req_read && req_write) begin
            req_busy  <= 1'b1;
            req_done  <= 1'b1;
            req_error <= 1'b1;
            state_reg <= DONE;
          end
        end
        ACCESS: begin
          if (wd_reg != WD_SAT) wd_reg <= wd_reg + 1'b1;
          // Completion takes priority over a timeout landing in the same cycle.
          if (cc_cmp) begin
            if (op_read_reg) req_rdata <= mem_rdata;
            req_error <= 1'b0;
            req_done  <= 1'b1;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            cc_enable <= 1'b0;
            state_reg <= DONE;
          end else if (wd_reg == WD_LAST) begin
            req_error <= 1'b1;
            req_done  <= 1'b1;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            cc_enable <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          wd_reg    <= '0;
          req_busy  <= 1'b0;
          req_error <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
